// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: default widths, ALU opcodes
// and the issue-stage state encoding.
package alu_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SELW  = 3;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MIN  = 3'b010;
  localparam logic [2:0] OP_MAX  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_XNOR = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/alu_issue_stage.sv
// Operand-issue / result-capture stage in front of the external combinational
// ALU, with a chaining accumulator and a saturating completed-op counter.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SELW  = DEF_SELW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [SELW-1:0]  cmd_sel,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_use_acc,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SELW-1:0]  alu_sel,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_y,
  output logic             res_cout,
  output logic [15:0]      op_count,
  input  logic             cnt_load,
  input  logic [15:0]      cnt_value,
  output state_e           state
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_r, b_r, acc;
  logic [SELW-1:0]  sel_r;
  logic             accept;
  logic             carry_op;

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // cmd_ready is high in IDLE, or in HOLD while the result is being taken,
  // so a new command can overlap the result handshake.
  assign cmd_ready = (state_q == IDLE) || ((state_q == HOLD) && res_ready);
  assign accept    = cmd_valid && cmd_ready;
  assign res_valid = (state_q == HOLD);
  assign state     = state_q;

  assign alu_a   = a_r;
  assign alu_b   = b_r;
  assign alu_sel = sel_r;

  // The ALU's cout is only meaningful for add and sub.
  assign carry_op = (sel_r == SELW'(OP_ADD)) || (sel_r == SELW'(OP_SUB));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = HOLD;
      HOLD:    if (res_ready) state_d = accept ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_r      <= '0;
      b_r      <= '0;
      sel_r    <= '0;
      res_y    <= '0;
      res_cout <= 1'b0;
      acc      <= '0;
      op_count <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_r   <= cmd_use_acc ? acc : cmd_a;
        b_r   <= cmd_b;
        sel_r <= cmd_sel;
      end
      if (state_q == EXEC) begin
        res_y    <= alu_y;
        res_cout <= carry_op ? alu_cout : 1'b0;
        acc      <= alu_y;
      end
      if (cnt_load) begin
        op_count <= cnt_value;
      end else if ((state_q == EXEC) && (op_count != 16'hFFFF)) begin
        op_count <= op_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: models the external ALU and checks
// every result against an operation-level reference with an expected queue.
module tb_alu_issue_stage;
  import alu_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_sel = '0;
  logic [W-1:0] cmd_a = '0;
  logic [W-1:0] cmd_b = '0;
  logic         cmd_use_acc = 1'b0;
  logic [W-1:0] alu_a, alu_b;
  logic [2:0]   alu_sel;
  logic [W-1:0] alu_y;
  logic         alu_cout;
  logic         res_valid;
  logic         res_ready = 1'b1;
  logic [W-1:0] res_y;
  logic         res_cout;
  logic [15:0]  op_count;
  logic         cnt_load = 1'b0;
  logic [15:0]  cnt_value = '0;
  state_e       dut_state;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] m_acc = '0;
  logic [15:0]  m_count = '0;
  logic [W:0]   exp_q[$];
  logic [W:0]   alu_r;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  alu_issue_stage dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_y(alu_y), .alu_cout(alu_cout),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_y(res_y), .res_cout(res_cout), .op_count(op_count),
    .cnt_load(cnt_load), .cnt_value(cnt_value), .state(dut_state)
  );

  // Reference result {cout, y} as the stage must present it.
  function automatic logic [W:0] ref_op(input logic [2:0] sel, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    case (sel)
      OP_ADD:  return {1'b0, a} + {1'b0, b};
      OP_SUB:  return {(a < b), a - b};
      OP_MIN:  return {1'b0, (a < b) ? a : b};
      OP_MAX:  return {1'b0, (a < b) ? b : a};
      OP_AND:  return {1'b0, a & b};
      OP_OR:   return {1'b0, a | b};
      OP_XOR:  return {1'b0, a ^ b};
      default: return {1'b0, ~(a ^ b)};
    endcase
  endfunction

  // External ALU model; cout is stale garbage (1) outside add/sub.
  always_comb begin
    alu_r    = ref_op(alu_sel, alu_a, alu_b);
    alu_y    = alu_r[W-1:0];
    alu_cout = ((alu_sel == OP_ADD) || (alu_sel == OP_SUB)) ? alu_r[W] : 1'b1;
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge with the DUT in IDLE, or in HOLD with res_ready=1.
  // Returns at a negedge in HOLD with res_ready=1.
  task automatic run_op(input logic [2:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic use_acc, input int stall, input string tag);
    logic [W-1:0] ea;
    logic [W:0]   exp;
    int           n;
    ea = use_acc ? m_acc : a;
    exp_q.push_back(ref_op(sel, ea, b));
    cmd_valid = 1'b1; cmd_sel = sel; cmd_a = a; cmd_b = b; cmd_use_acc = use_acc;
    #1;
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s accept: cmd_ready=%b, required 1", tag, cmd_ready);
    end
    n = 0;
    while (cmd_ready !== 1'b1 && n < 8) begin @(negedge clk); #1; n++; end
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0; cmd_use_acc = 1'b0; res_ready = (stall == 0);
    vectors++;
    if ({res_valid, cmd_ready, alu_a, alu_b, alu_sel} !== {1'b0, 1'b0, ea, b, sel}) begin
      miscompares++;
      $display("FAIL %s exec: valid=%b ready=%b alu a=%h b=%h sel=%0d, required 0 0 %h %h %0d",
               tag, res_valid, cmd_ready, alu_a, alu_b, alu_sel, ea, b, sel);
    end
    @(posedge clk); @(negedge clk);
    exp = exp_q.pop_front();
    m_acc = exp[W-1:0];
    if (m_count != 16'hFFFF) m_count++;
    vectors++;
    if (res_valid !== 1'b1 || {res_cout, res_y} !== exp) begin
      miscompares++;
      $display("FAIL %s result: valid=%b cout=%b y=%h, required 1 %b %h",
               tag, res_valid, res_cout, res_y, exp[W], exp[W-1:0]);
    end
    vectors++;
    if (op_count !== m_count) begin
      miscompares++;
      $display("FAIL %s op_count: got %h, required %h", tag, op_count, m_count);
    end
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); @(negedge clk);
      vectors++;
      if (res_valid !== 1'b1 || cmd_ready !== 1'b0 || {res_cout, res_y} !== exp ||
          op_count !== m_count) begin
        miscompares++;
        $display("FAIL %s stall%0d: valid=%b ready=%b cout=%b y=%h cnt=%h, required 1 0 %b %h %h",
                 tag, i, res_valid, cmd_ready, res_cout, res_y, op_count, exp[W], exp[W-1:0], m_count);
      end
    end
    res_ready = 1'b1;
  endtask

  task automatic drain(input string tag);
    @(posedge clk); @(negedge clk);
    vectors++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || dut_state !== IDLE || op_count !== m_count) begin
      miscompares++;
      $display("FAIL %s drain: valid=%b ready=%b state=%0d cnt=%h, required 0 1 %0d %h",
               tag, res_valid, cmd_ready, dut_state, op_count, IDLE, m_count);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({cmd_ready, res_valid, res_y, res_cout, op_count, alu_a, alu_b, alu_sel} !==
        {1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 16'h0, 3'b0} || dut_state !== IDLE) begin
      miscompares++;
      $display("FAIL reset: ready=%b valid=%b y=%h cout=%b cnt=%h a=%h b=%h sel=%0d state=%0d, required 1 0 0 0 0 0 0 0 0",
               cmd_ready, res_valid, res_y, res_cout, op_count, alu_a, alu_b, alu_sel, dut_state);
    end
    rst = 1'b0;
    m_acc = '0; m_count = '0;
  endtask

  task automatic test_add();
    run_op(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 0, "add_carry");
    drain("add_carry");
  endtask

  task automatic test_sub_mask();
    run_op(OP_SUB, 16'h0003, 16'h0005, 1'b0, 0, "sub_borrow");
    drain("sub_borrow");
    run_op(OP_XNOR, 16'h00F0, 16'h0FF0, 1'b0, 0, "xnor_mask");
    drain("xnor_mask");
    run_op(OP_MAX, 16'h1234, 16'h8000, 1'b0, 0, "max_mask");
    drain("max_mask");
  endtask

  task automatic test_back_to_back();
    run_op(OP_ADD, 16'h0010, 16'h0020, 1'b0, 0, "chain0");
    run_op(OP_ADD, 16'hDEAD, 16'h0005, 1'b1, 0, "chain1");
    drain("chain");
  endtask

  task automatic test_backpressure();
    run_op(OP_SUB, 16'h4000, 16'h0123, 1'b0, 5, "backpressure");
    drain("backpressure");
  endtask

  task automatic test_reset_mid_op();
    cmd_valid = 1'b1; cmd_sel = OP_ADD; cmd_a = 16'h1111; cmd_b = 16'h2222; cmd_use_acc = 1'b0;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    vectors++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || op_count !== 16'h0 || dut_state !== IDLE) begin
      miscompares++;
      $display("FAIL reset_mid_op: valid=%b ready=%b cnt=%h state=%0d, required 0 1 0 0",
               res_valid, cmd_ready, op_count, dut_state);
    end
    rst = 1'b0;
    m_acc = '0; m_count = '0;
    run_op(OP_OR, 16'hABCD, 16'h0007, 1'b1, 0, "acc_after_reset");
    drain("acc_after_reset");
  endtask

  task automatic test_saturation();
    cnt_load = 1'b1; cnt_value = 16'hFFFE;
    @(posedge clk); @(negedge clk);
    cnt_load = 1'b0;
    m_count = 16'hFFFE;
    vectors++;
    if (op_count !== 16'hFFFE) begin
      miscompares++;
      $display("FAIL preload: op_count=%h, required fffe", op_count);
    end
    run_op(OP_AND, 16'hF0F0, 16'h3C3C, 1'b0, 0, "sat_reach");
    run_op(OP_XOR, 16'h0000, 16'h5A5A, 1'b1, 0, "sat_hold0");
    run_op(OP_ADD, 16'h0001, 16'h0001, 1'b0, 1, "sat_hold1");
    drain("saturation");
  endtask

  task automatic test_random();
    for (int k = 0; k < 60; k++) begin
      run_op(3'($urandom_range(7)), W'($urandom), W'($urandom), 1'($urandom_range(1)),
             $urandom_range(2), "random");
      if ($urandom_range(1) == 1) drain("random");
    end
    drain("random_end");
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    @(negedge clk);
    test_reset();
    test_add();
    test_sub_mask();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_op();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
